// File: rtl/eci_cmd_defs.sv
// ECI command word definitions shared by the receive packetization path.
// Provides the 64-bit ECI word type and the packet-size counter width.
// Only the generic command view is described; other opcode views overlay the same bits.
package eci_cmd_defs;

  localparam int ECI_WORD_WIDTH        = 64;
  // Wide enough to hold the largest packet length (17 words).
  localparam int ECI_PACKET_SIZE_WIDTH = 5;

  typedef struct packed {
    logic [4:0]  opcode;
    logic        xb1;
    logic [5:0]  hreq_id;
    logic [3:0]  dmask;     // one bit per sub-cache-line carried after the header
    logic        ns;
    logic [46:0] rsvd;
  } eci_generic_cmd_t;

  typedef union packed {
    eci_generic_cmd_t                generic_cmd;
    logic [ECI_WORD_WIDTH-1:0]       raw;
  } eci_word_t;

endpackage

// File: rtl/eci_word_to_pkt_asm.sv
// Purpose: assembles a header plus its dmask-derived data words into one parallel ECI packet.
// Latency: last word accepted in cycle N-1 -> ds_valid_o in cycle N (single-word packet: cycle 1).
// Backpressure: us_ready_o drops only while a packet is held FULL and ds_ready_i is low.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   us_word_i/us_vc_i     : upstream ECI word and its VC tag, valid/ready handshake
//   ds_pkt_o/ds_size_o    : assembled packet (word k at [64k+63:64k]) and its word count
//   ds_vc_o               : VC latched from the header, valid/ready handshake on ds_valid_o
//   err_o                 : one-cycle VC-mismatch pulse, only with ECI_PKT_ASM_VC_CHECK_EN
//                           defined; constant 0 otherwise
module eci_word_to_pkt_asm
  import eci_cmd_defs::*;
#(
  parameter int MAX_PKT_WORDS = 17,
  parameter int VC_W          = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ECI_WORD_WIDTH-1:0]        us_word_i,
  input  logic [VC_W-1:0]                  us_vc_i,
  input  logic                             us_valid_i,
  output logic                             us_ready_o,
  output logic [MAX_PKT_WORDS*64-1:0]      ds_pkt_o,
  output logic [ECI_PACKET_SIZE_WIDTH-1:0] ds_size_o,
  output logic [VC_W-1:0]                  ds_vc_o,
  output logic                             ds_valid_o,
  input  logic                             ds_ready_i,
  output logic                             err_o
);

  localparam int IDX_W = $clog2(MAX_PKT_WORDS);
  localparam int SW    = ECI_PACKET_SIZE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q,  idx_d;
  logic [SW-1:0]   size_q,  size_d;
  logic [VC_W-1:0] vc_q,    vc_d;
  logic [63:0]     buf_q [MAX_PKT_WORDS];
  logic [63:0]     buf_d [MAX_PKT_WORDS];

  eci_word_t       in_word;
  logic [2:0]      dmask_ones;
  logic [SW-1:0]   num_words;
  logic            hdr_take;

  assign in_word = us_word_i;

  // Header length: one header word plus four words per set dmask bit.
  always_comb begin
    dmask_ones = 3'($countones(in_word.generic_cmd.dmask));
    num_words  = SW'({dmask_ones, 2'b00}) + SW'(1);
  end

  // FULL is the only state that can refuse a word; freeing it through ds_ready_i
  // in the same cycle lets the next header land with no dead cycle.
  assign us_ready_o = (state_q != S_FULL) || ds_ready_i;
  assign ds_valid_o = (state_q == S_FULL);
  assign ds_size_o  = size_q;
  assign ds_vc_o    = vc_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    size_d   = size_q;
    vc_d     = vc_q;
    buf_d    = buf_q;
    hdr_take = 1'b0;

    case (state_q)
      S_IDLE: begin
        hdr_take = us_valid_i;
      end
      S_COLLECT: begin
        if (us_valid_i) begin
          buf_d[idx_q] = us_word_i;
          if (idx_q == IDX_W'(size_q - SW'(1))) begin
            state_d = S_FULL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (ds_ready_i) begin
          state_d  = S_IDLE;
          // The held packet leaves on this edge, so word 0 may be reused now.
          hdr_take = us_valid_i;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (hdr_take) begin
      buf_d[0] = in_word;
      size_d   = num_words;
      vc_d     = us_vc_i;
      if (num_words == SW'(1)) begin
        state_d = S_FULL;
        idx_d   = '0;
      end else begin
        state_d = S_COLLECT;
        idx_d   = IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      size_q  <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      size_q  <= size_d;
      vc_q    <= vc_d;
    end
  end

  // Payload storage carries no reset; words beyond ds_size_o are don't-care.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  for (genvar k = 0; k < MAX_PKT_WORDS; k++) begin : g_pkt
    assign ds_pkt_o[64*k +: 64] = buf_q[k];
  end

`ifdef ECI_PKT_ASM_VC_CHECK_EN
  logic err_q, err_d;

  // Data words must share the header's VC; a mismatch is flagged but the word is kept.
  always_comb begin
    err_d = (state_q == S_COLLECT) && us_valid_i && (us_vc_i != vc_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_eci_word_to_pkt_asm.sv
// Self-checking bench for eci_word_to_pkt_asm: directed scenarios plus randomized streams
// compared against a packet-level reference model (size from dmask popcount, FIFO order).
module tb_eci_word_to_pkt_asm;
  import eci_cmd_defs::*;

  localparam int MW = 17;
  localparam int VW = 5;
  localparam int SW = ECI_PACKET_SIZE_WIDTH;

  typedef struct packed {
    logic [SW-1:0]      size;
    logic [VW-1:0]      vc;
    logic [MW*64-1:0]   w;
  } pkt_t;

  logic               clk;
  logic               reset;
  logic [63:0]        us_word_i;
  logic [VW-1:0]      us_vc_i;
  logic               us_valid_i;
  logic               us_ready_o;
  logic [MW*64-1:0]   ds_pkt_o;
  logic [SW-1:0]      ds_size_o;
  logic [VW-1:0]      ds_vc_o;
  logic               ds_valid_o;
  logic               ds_ready_i;
  logic               err_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  pkt_t sb[$];
  int   early_valid, err_seen, err_at, span, stall_cnt;
  bit   drv_done;

  eci_word_to_pkt_asm #(.MAX_PKT_WORDS(MW), .VC_W(VW)) dut (
    .clk        (clk),
    .reset      (reset),
    .us_word_i  (us_word_i),
    .us_vc_i    (us_vc_i),
    .us_valid_i (us_valid_i),
    .us_ready_o (us_ready_o),
    .ds_pkt_o   (ds_pkt_o),
    .ds_size_o  (ds_size_o),
    .ds_vc_o    (ds_vc_o),
    .ds_valid_o (ds_valid_o),
    .ds_ready_i (ds_ready_i),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt + 1);
    $fatal(1, "watchdog");
  end

  // Reference packet: header with the requested dmask, length 1 + 4*popcount(dmask).
  function automatic pkt_t build_pkt(input logic [3:0] dm, input logic [VW-1:0] vc, input bit idx_data);
    pkt_t      p;
    eci_word_t h;
    p.w = '0;
    h.raw = {$urandom, $urandom};
    h.generic_cmd.dmask = dm;
    p.size = SW'(1 + 4 * $countones(dm));
    p.vc = vc;
    p.w[63:0] = h.raw;
    for (int k = 1; k < int'(p.size); k++)
      p.w[64*k +: 64] = idx_data ? 64'(k) : {$urandom, $urandom};
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one packet word by word; bubble 0 = none, 1 = every other cycle, 2 = random.
  // Records whether ds_valid_o rose early, err_o pulses and edges spanned.
  task automatic drive_pkt(input pkt_t p, input int bubble, input int bad_idx, input logic [VW-1:0] bad_vc);
    int t;
    early_valid = 0; err_seen = 0; err_at = -1; span = 0;
    for (int k = 0; k < int'(p.size); k++) begin
      if ((bubble == 1 && k > 0) || (bubble == 2 && $urandom_range(1) == 1)) begin
        us_valid_i = 1'b0;
        tick();
        if (k > 0) span++;
        if (err_o) begin err_seen++; err_at = 100; end
        if (k > 0 && ds_valid_o) early_valid = 1;
      end
      us_valid_i = 1'b1;
      us_word_i  = p.w[64*k +: 64];
      us_vc_i    = (k == bad_idx) ? bad_vc : p.vc;
      t = 0;
      while (!us_ready_o && t < 200) begin tick(); t++; end
      if (t >= 200) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL drive_timeout: us_ready_o=%0b after %0d cycles, required 1", us_ready_o, t);
      end
      if (k > 0 && ds_valid_o) early_valid = 1;
      tick();
      if (k > 0) span++;
      if (err_o) begin err_seen++; err_at = k; end
    end
    us_valid_i = 1'b0;
  endtask

  task automatic consume();
    ds_ready_i = 1'b1;
    tick();
    ds_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; us_valid_i = 1'b0; ds_ready_i = 1'b0; us_word_i = '0; us_vc_i = '0;
    repeat (3) tick();
    vec_cnt++; if (ds_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL reset_valid: got %0b want 0", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== '0) begin miss_cnt++; $display("FAIL reset_size: got %0d want 0", ds_size_o); end
    vec_cnt++; if (ds_vc_o !== '0) begin miss_cnt++; $display("FAIL reset_vc: got %0d want 0", ds_vc_o); end
    vec_cnt++; if (err_o !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %0b want 0", err_o); end
    vec_cnt++; if (us_ready_o !== 1'b1) begin miss_cnt++; $display("FAIL reset_ready: got %0b want 1", us_ready_o); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    pkt_t p = build_pkt(4'b0000, VW'(3), 1'b0);
    drive_pkt(p, 0, -1, '0);
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL single_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== SW'(1)) begin miss_cnt++; $display("FAIL single_size: got %0d want 1", ds_size_o); end
    vec_cnt++; if (ds_vc_o !== VW'(3)) begin miss_cnt++; $display("FAIL single_vc: got %0d want 3", ds_vc_o); end
    vec_cnt++; if (ds_pkt_o[63:0] !== p.w[63:0]) begin miss_cnt++; $display("FAIL single_hdr: got %h want %h", ds_pkt_o[63:0], p.w[63:0]); end
    consume();
    vec_cnt++; if (ds_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL single_drain: got %0b want 0", ds_valid_o); end
  endtask

  task automatic test_full17();
    pkt_t p = build_pkt(4'b1111, VW'($urandom), 1'b1);
    drive_pkt(p, 0, -1, '0);
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL full17_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (early_valid != 0) begin miss_cnt++; $display("FAIL full17_early: got %0d want 0", early_valid); end
    vec_cnt++; if (span != 16) begin miss_cnt++; $display("FAIL full17_span: got %0d want 16", span); end
    vec_cnt++; if (ds_size_o !== SW'(17)) begin miss_cnt++; $display("FAIL full17_size: got %0d want 17", ds_size_o); end
    vec_cnt++; if (ds_vc_o !== p.vc) begin miss_cnt++; $display("FAIL full17_vc: got %0d want %0d", ds_vc_o, p.vc); end
    for (int k = 0; k < 17; k++) begin
      vec_cnt++;
      if (ds_pkt_o[64*k +: 64] !== p.w[64*k +: 64]) begin
        miss_cnt++; $display("FAIL full17_word%0d: got %h want %h", k, ds_pkt_o[64*k +: 64], p.w[64*k +: 64]);
      end
    end
    consume();
  endtask

  task automatic test_bubbles();
    pkt_t p = build_pkt(4'b0101, VW'($urandom), 1'b0);
    drive_pkt(p, 1, -1, '0);
    vec_cnt++; if (early_valid != 0) begin miss_cnt++; $display("FAIL bubbles_early: got %0d want 0", early_valid); end
    vec_cnt++; if (span != 16) begin miss_cnt++; $display("FAIL bubbles_span: got %0d want 16", span); end
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL bubbles_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== SW'(9)) begin miss_cnt++; $display("FAIL bubbles_size: got %0d want 9", ds_size_o); end
    for (int k = 0; k < 9; k++) begin
      vec_cnt++;
      if (ds_pkt_o[64*k +: 64] !== p.w[64*k +: 64]) begin
        miss_cnt++; $display("FAIL bubbles_word%0d: got %h want %h", k, ds_pkt_o[64*k +: 64], p.w[64*k +: 64]);
      end
    end
    consume();
  endtask

  task automatic test_hold_b2b();
    pkt_t p  = build_pkt(4'($urandom_range(15, 1)), VW'($urandom), 1'b0);
    pkt_t p2 = build_pkt(4'b0000, VW'($urandom), 1'b0);
    drive_pkt(p, 0, -1, '0);
    ds_ready_i = 1'b0;
    us_valid_i = 1'b1; us_word_i = p2.w[63:0]; us_vc_i = p2.vc;
    for (int i = 0; i < 5; i++) begin
      vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL hold_valid%0d: got %0b want 1", i, ds_valid_o); end
      vec_cnt++; if (us_ready_o !== 1'b0) begin miss_cnt++; $display("FAIL hold_ready%0d: got %0b want 0", i, us_ready_o); end
      vec_cnt++; if (ds_size_o !== p.size) begin miss_cnt++; $display("FAIL hold_size%0d: got %0d want %0d", i, ds_size_o, p.size); end
      vec_cnt++; if (ds_vc_o !== p.vc) begin miss_cnt++; $display("FAIL hold_vc%0d: got %0d want %0d", i, ds_vc_o, p.vc); end
      vec_cnt++; if (ds_pkt_o[63:0] !== p.w[63:0]) begin miss_cnt++; $display("FAIL hold_hdr%0d: got %h want %h", i, ds_pkt_o[63:0], p.w[63:0]); end
      tick();
    end
    ds_ready_i = 1'b1;
    #1;
    vec_cnt++; if (us_ready_o !== 1'b1) begin miss_cnt++; $display("FAIL b2b_ready: got %0b want 1", us_ready_o); end
    tick();
    ds_ready_i = 1'b0; us_valid_i = 1'b0;
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL b2b_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== SW'(1)) begin miss_cnt++; $display("FAIL b2b_size: got %0d want 1", ds_size_o); end
    vec_cnt++; if (ds_vc_o !== p2.vc) begin miss_cnt++; $display("FAIL b2b_vc: got %0d want %0d", ds_vc_o, p2.vc); end
    vec_cnt++; if (ds_pkt_o[63:0] !== p2.w[63:0]) begin miss_cnt++; $display("FAIL b2b_hdr: got %h want %h", ds_pkt_o[63:0], p2.w[63:0]); end
    consume();
    vec_cnt++; if (ds_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL b2b_drain: got %0b want 0", ds_valid_o); end
  endtask

  task automatic test_reset_mid();
    pkt_t p  = build_pkt(4'b0101, VW'($urandom), 1'b0);
    pkt_t p2 = build_pkt(4'($urandom_range(15)), VW'($urandom), 1'b0);
    pkt_t p3 = build_pkt(4'b0000, VW'($urandom), 1'b0);
    for (int k = 0; k < 3; k++) begin
      us_valid_i = 1'b1; us_word_i = p.w[64*k +: 64]; us_vc_i = p.vc;
      tick();
    end
    us_valid_i = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++; if (ds_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL rstmid_valid: got %0b want 0", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== '0) begin miss_cnt++; $display("FAIL rstmid_size: got %0d want 0", ds_size_o); end
    drive_pkt(p2, 2, -1, '0);
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL rstmid_next_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (ds_size_o !== p2.size) begin miss_cnt++; $display("FAIL rstmid_next_size: got %0d want %0d", ds_size_o, p2.size); end
    vec_cnt++; if (ds_vc_o !== p2.vc) begin miss_cnt++; $display("FAIL rstmid_next_vc: got %0d want %0d", ds_vc_o, p2.vc); end
    for (int k = 0; k < int'(p2.size); k++) begin
      vec_cnt++;
      if (ds_pkt_o[64*k +: 64] !== p2.w[64*k +: 64]) begin
        miss_cnt++; $display("FAIL rstmid_word%0d: got %h want %h", k, ds_pkt_o[64*k +: 64], p2.w[64*k +: 64]);
      end
    end
    consume();
    // A held FULL packet is dropped by reset as well.
    drive_pkt(p3, 0, -1, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vec_cnt++; if (ds_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL rstfull_valid: got %0b want 0", ds_valid_o); end
    vec_cnt++; if (us_ready_o !== 1'b1) begin miss_cnt++; $display("FAIL rstfull_ready: got %0b want 1", us_ready_o); end
  endtask

  task automatic test_vc_check();
    pkt_t p = build_pkt(4'b0011, VW'(2), 1'b0);
    int   exp_pulses;
`ifdef ECI_PKT_ASM_VC_CHECK_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    drive_pkt(p, 0, 2, VW'(4));
    vec_cnt++; if (err_seen != exp_pulses) begin miss_cnt++; $display("FAIL vc_err_pulses: got %0d want %0d", err_seen, exp_pulses); end
    if (exp_pulses == 1) begin
      vec_cnt++; if (err_at != 2) begin miss_cnt++; $display("FAIL vc_err_timing: got word %0d want word 2", err_at); end
    end
    vec_cnt++; if (ds_valid_o !== 1'b1) begin miss_cnt++; $display("FAIL vc_valid: got %0b want 1", ds_valid_o); end
    vec_cnt++; if (ds_vc_o !== VW'(2)) begin miss_cnt++; $display("FAIL vc_latched: got %0d want 2", ds_vc_o); end
    vec_cnt++; if (ds_size_o !== SW'(9)) begin miss_cnt++; $display("FAIL vc_size: got %0d want 9", ds_size_o); end
    vec_cnt++; if (ds_pkt_o[64*2 +: 64] !== p.w[64*2 +: 64]) begin miss_cnt++; $display("FAIL vc_word2: got %h want %h", ds_pkt_o[64*2 +: 64], p.w[64*2 +: 64]); end
    consume();
  endtask

  // Free-running stream: random packets, bubbles and downstream stalls, scoreboarded in order.
  task automatic run_stream(input int npkts, input int bubble_pct, input int ready_pct);
    drv_done = 1'b0; stall_cnt = 0; sb.delete();
    fork
      begin : driver
        for (int i = 0; i < npkts; i++) begin
          pkt_t p = build_pkt(4'($urandom_range(15)), VW'($urandom), 1'b0);
          sb.push_back(p);
          for (int k = 0; k < int'(p.size); k++) begin
            bit acc;
            int t;
            while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
              us_valid_i = 1'b0;
              tick();
            end
            us_valid_i = 1'b1; us_word_i = p.w[64*k +: 64]; us_vc_i = p.vc;
            acc = 1'b0; t = 0;
            while (!acc && t < 500) begin
              @(negedge clk);
              acc = us_ready_o;
              if (!acc) stall_cnt++;
              tick();
              t++;
            end
            if (!acc) begin
              vec_cnt++; miss_cnt++;
              $display("FAIL stream_drive_timeout: word not accepted in %0d cycles, required acceptance", t);
            end
          end
        end
        us_valid_i = 1'b0;
        drv_done = 1'b1;
      end
      begin : monitor
        int cyc = 0;
        bit prev_hold = 1'b0;
        logic [SW-1:0] prev_size = '0;
        while (cyc < 20000 && !(drv_done && sb.size() == 0)) begin
          ds_ready_i = ($urandom_range(99) < ready_pct);
          @(negedge clk);
          vec_cnt++;
          if (us_ready_o !== (!ds_valid_o || ds_ready_i)) begin
            miss_cnt++; $display("FAIL stream_ready: got %0b want %0b", us_ready_o, (!ds_valid_o || ds_ready_i));
          end
          vec_cnt++;
          if (err_o !== 1'b0) begin miss_cnt++; $display("FAIL stream_err: got %0b want 0", err_o); end
          if (prev_hold) begin
            vec_cnt++;
            if (ds_valid_o !== 1'b1 || ds_size_o !== prev_size) begin
              miss_cnt++; $display("FAIL stream_hold: valid=%0b size=%0d want valid=1 size=%0d", ds_valid_o, ds_size_o, prev_size);
            end
          end
          if (ds_valid_o && ds_ready_i) begin
            vec_cnt++;
            if (sb.size() == 0) begin
              miss_cnt++; $display("FAIL stream_extra: got unexpected packet size %0d want none", ds_size_o);
            end else begin
              pkt_t e = sb.pop_front();
              bit ok = (ds_size_o === e.size) && (ds_vc_o === e.vc);
              for (int k = 0; k < int'(e.size); k++)
                if (ds_pkt_o[64*k +: 64] !== e.w[64*k +: 64]) ok = 1'b0;
              if (!ok) begin
                miss_cnt++;
                $display("FAIL stream_pkt: got size %0d vc %0d hdr %h want size %0d vc %0d hdr %h",
                         ds_size_o, ds_vc_o, ds_pkt_o[63:0], e.size, e.vc, e.w[63:0]);
              end
            end
          end
          prev_hold = ds_valid_o && !ds_ready_i;
          prev_size = ds_size_o;
          tick();
          cyc++;
        end
        if (cyc >= 20000) begin
          vec_cnt++; miss_cnt++;
          $display("FAIL stream_timeout: %0d packets outstanding after %0d cycles, required 0", sb.size(), cyc);
        end
        ds_ready_i = 1'b0;
      end
    join
    tick();
  endtask

  task automatic test_random();
    run_stream(40, 30, 60);
  endtask

  task automatic test_back_to_back();
    run_stream(6, 0, 100);
    vec_cnt++;
    if (stall_cnt != 0) begin miss_cnt++; $display("FAIL b2b_stream_stalls: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full17();
    test_bubbles();
    test_hold_b2b();
    test_reset_mid();
    test_vc_check();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
